// File: rtl/sipo_frame_deser.sv
// Serial-in / parallel-out frame deserializer with a one-frame holding slot,
// configurable shift direction, output bit reversal and sticky overflow.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_COLLECT | accepting serial bits into the shift register (in_ready=1)
// ST_PENDING | complete frame waits for the output register (in_ready=0)
module sipo_frame_deser #(
    parameter  int DATA_WIDTH = 32,
    localparam int LEN_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic                  in_ready,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic                  shift_dir,
    input  logic                  out_dir,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LEN_W-1:0]      bit_cnt,
    output logic                  overflow
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] pend_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [LEN_W-1:0]      n_q;
    logic                  sd_q;
    logic                  od_q;
    logic                  out_valid_q;
    logic                  ovf_q;

    logic                  frame_start;
    logic [LEN_W-1:0]      n_in;
    logic [LEN_W-1:0]      n_eff;
    logic                  sd_eff;
    logic                  od_eff;
    logic                  accept;
    logic [LEN_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [DATA_WIDTH-1:0] rev_full;
    logic [DATA_WIDTH-1:0] frame_fmt;
    logic                  frame_done;
    logic                  out_fire;
    logic                  out_free;

    // Framing comes straight from the inputs on the first bit, from the latch after.
    always_comb begin
        frame_start = (cnt_q == '0);
        n_in        = ((frame_len == '0) || (frame_len > LEN_MAX)) ? LEN_MAX : frame_len;
        n_eff       = frame_start ? n_in      : n_q;
        sd_eff      = frame_start ? shift_dir : sd_q;
        od_eff      = frame_start ? out_dir   : od_q;
        in_ready    = (state == ST_COLLECT);
        accept      = serial_valid && in_ready;
        bit_idx     = sd_eff ? (n_eff - LEN_ONE - cnt_q) : cnt_q;
        shift_nxt   = (frame_start ? '0 : shift_q) | (DATA_WIDTH'(serial_in) << bit_idx);
        frame_done  = accept && !flush && ((cnt_q + LEN_ONE) == n_eff);
        out_fire    = out_valid_q && out_ready;
        out_free    = !out_valid_q || out_ready;
    end

    // Reversing the full word and shifting down by the unused width reverses within N.
    always_comb begin
        rev_full = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rev_full[i] = shift_nxt[DATA_WIDTH-1-i];
        end
        frame_fmt = od_eff ? (rev_full >> (LEN_MAX - n_eff)) : shift_nxt;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= ST_COLLECT;
            shift_q     <= '0;
            pend_q      <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            sd_q        <= 1'b0;
            od_q        <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (serial_valid && !in_ready) begin
                ovf_q <= 1'b1;
            end
            if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                ST_COLLECT: begin
                    if (flush) begin
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end else if (accept) begin
                        if (frame_start) begin
                            n_q  <= n_in;
                            sd_q <= shift_dir;
                            od_q <= out_dir;
                        end
                        if (frame_done) begin
                            cnt_q   <= '0;
                            shift_q <= '0;
                            if (out_free) begin
                                out_q       <= frame_fmt;
                                out_valid_q <= 1'b1;
                            end else begin
                                pend_q <= frame_fmt;
                                state  <= ST_PENDING;
                            end
                        end else begin
                            cnt_q   <= cnt_q + LEN_ONE;
                            shift_q <= shift_nxt;
                        end
                    end
                end
                ST_PENDING: begin
                    if (out_fire) begin
                        out_q       <= pend_q;
                        out_valid_q <= 1'b1;
                        state       <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    assign parallel_out = out_q;
    assign out_valid    = out_valid_q;
    assign bit_cnt      = cnt_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_sipo_frame_deser.sv
// Directed scenarios plus a randomized run scored against a queue-based
// frame model for sipo_frame_deser at DATA_WIDTH=8.
module tb_sipo_frame_deser;

    localparam int DW = 8;
    localparam int LW = $clog2(DW) + 1;

    logic          clk = 1'b0;
    logic          srst;
    logic          serial_in;
    logic          serial_valid;
    logic          in_ready;
    logic [LW-1:0] frame_len;
    logic          shift_dir;
    logic          out_dir;
    logic          flush;
    logic [DW-1:0] parallel_out;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] bit_cnt;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mbits;
    int         mcnt, mn;
    bit         msd, mod;
    int         pushed, popped;

    sipo_frame_deser #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .srst(srst), .serial_in(serial_in), .serial_valid(serial_valid),
        .in_ready(in_ready), .frame_len(frame_len), .shift_dir(shift_dir),
        .out_dir(out_dir), .flush(flush), .parallel_out(parallel_out),
        .out_valid(out_valid), .out_ready(out_ready), .bit_cnt(bit_cnt),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends bits[n-1] first, so a sequence reads left to right as written.
    task automatic send_seq(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            serial_valid = 1'b1;
            serial_in    = bits[k];
            tick();
        end
        serial_valid = 1'b0;
    endtask

    function automatic int n_of(input logic [LW-1:0] len);
        return (len == 0 || int'(len) > DW) ? DW : int'(len);
    endfunction

    // b[k] is the k-th bit received; arithmetic build, then optional reversal.
    function automatic logic [7:0] ref_frame(input logic [7:0] b, input int n,
                                             input bit sd, input bit od);
        int v, r;
        v = 0;
        for (int k = 0; k < n; k++) begin
            if (sd) v = v * 2 + int'(b[k]);
            else    v = v + (int'(b[k]) << k);
        end
        if (od) begin
            r = 0;
            for (int i = 0; i < n; i++) r = r | (((v >> i) & 1) << (n - 1 - i));
            v = r;
        end
        return v[7:0];
    endfunction

    // One random cycle: outputs checked against the model, then new stimulus.
    task automatic rand_cycle(input bit allow_bits, input bit force_ready);
        logic [7:0] front;
        chk("rnd_in_ready", in_ready, exp_q.size() < 2);
        chk("rnd_out_valid", out_valid, exp_q.size() > 0);
        chk("rnd_bit_cnt", bit_cnt, mcnt);
        chk("rnd_overflow", overflow, 0);
        out_ready    = force_ready ? 1'b1 : 1'($urandom_range(0, 1));
        frame_len    = LW'($urandom_range(0, 15));
        shift_dir    = 1'($urandom_range(0, 1));
        out_dir      = 1'($urandom_range(0, 1));
        serial_in    = 1'($urandom_range(0, 1));
        serial_valid = allow_bits && (exp_q.size() < 2) && ($urandom_range(0, 9) < 7);
        if (exp_q.size() > 0 && out_ready) begin
            front = exp_q.pop_front();
            popped++;
            chk("rnd_frame", parallel_out, front);
        end
        if (serial_valid) begin
            if (mcnt == 0) begin
                mn  = n_of(frame_len);
                msd = shift_dir;
                mod = out_dir;
            end
            mbits[mcnt] = serial_in;
            mcnt++;
            if (mcnt == mn) begin
                exp_q.push_back(ref_frame(mbits, mn, msd, mod));
                pushed++;
                mcnt = 0;
            end
        end
        tick();
    endtask

    initial begin
        int cyc;
        srst = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; frame_len = '0;
        shift_dir = 1'b1; out_dir = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_parallel", parallel_out, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_overflow", overflow, 0);
        srst = 1'b0;
        tick();

        // Basic 4-bit frames in each order
        frame_len = 4; shift_dir = 1; out_dir = 0;
        send_seq(16'b10, 2);
        chk("cnt_mid", bit_cnt, 2);
        send_seq(16'b11, 2);
        chk("sd1_od0_valid", out_valid, 1);
        chk("sd1_od0_data", parallel_out, 8'h0B);
        chk("sd1_od0_cnt", bit_cnt, 0);
        tick();
        chk("sd1_od0_drop", out_valid, 0);

        shift_dir = 0; out_dir = 0;
        send_seq(16'b1011, 4);
        chk("sd0_od0_data", parallel_out, 8'h0D);
        shift_dir = 1; out_dir = 1;
        send_seq(16'b1011, 4);
        chk("sd1_od1_data", parallel_out, 8'h0D);
        shift_dir = 0; out_dir = 1;
        send_seq(16'b1011, 4);
        chk("sd0_od1_data", parallel_out, 8'h0B);

        // Mid-frame parameter changes wait for the next frame
        frame_len = 4; shift_dir = 1; out_dir = 0;
        send_seq(16'b1, 1);
        frame_len = 2; shift_dir = 0; out_dir = 1;
        send_seq(16'b001, 3);
        chk("midchg_data", parallel_out, 8'h09);
        frame_len = 12; shift_dir = 1; out_dir = 0;
        send_seq(16'h96, 8);
        chk("len_over_data", parallel_out, 8'h96);
        tick();

        // Backpressure: second frame parks, extra bit overflows
        out_ready = 0; frame_len = 8; shift_dir = 1; out_dir = 0;
        send_seq(16'hA5, 8);
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_data", parallel_out, 8'hA5);
        send_seq(16'h3C, 8);
        chk("bp_in_ready", in_ready, 0);
        tick(); tick();
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", parallel_out, 8'hA5);
        chk("bp_no_ovf", overflow, 0);
        flush = 1; send_seq(16'b1, 1); flush = 0;
        chk("bp_overflow", overflow, 1);
        chk("bp_still_parked", in_ready, 0);
        out_ready = 1;
        tick();
        chk("bp_second_data", parallel_out, 8'h3C);
        chk("bp_second_valid", out_valid, 1);
        chk("bp_ready_back", in_ready, 1);
        tick();
        chk("bp_drained", out_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);

        // frame_len = 0 means full width
        frame_len = 0;
        send_seq(16'h7F, 7);
        chk("len0_cnt7", bit_cnt, 7);
        send_seq(16'b1, 1);
        chk("len0_data", parallel_out, 8'hFF);
        chk("len0_cnt0", bit_cnt, 0);
        tick();

        // Reset mid-frame
        frame_len = 4;
        send_seq(16'b101, 3);
        srst = 1; tick(); srst = 0;
        chk("srst_cnt", bit_cnt, 0);
        chk("srst_valid", out_valid, 0);
        chk("srst_ovf", overflow, 0);
        send_seq(16'b1100, 4);
        chk("srst_next_data", parallel_out, 8'h0C);

        // Flush discards the partial frame and a same-edge bit
        send_seq(16'b11, 2);
        flush = 1; serial_valid = 1; serial_in = 1; tick();
        flush = 0; serial_valid = 0;
        chk("flush_cnt", bit_cnt, 0);
        send_seq(16'b0110, 4);
        chk("flush_data", parallel_out, 8'h06);
        tick();

        // Randomized run against the frame model
        mcnt = 0; mn = DW; mbits = '0; pushed = 0; popped = 0; cyc = 0;
        while (pushed < 40 && cyc < 4000) begin
            rand_cycle(1'b1, 1'b0);
            cyc++;
        end
        chk("rnd_budget", cyc < 4000, 1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            rand_cycle(1'b0, 1'b1);
            cyc++;
        end
        chk("rnd_all_popped", popped, pushed);
        chk("rnd_final_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
